// File: rtl/pkt_pkg.sv
// rtl/pkt_pkg.sv - shared link-format constants, tx state type and checksum helper
package pkt_pkg;

  localparam logic [7:0] SOF0     = 8'hBE;
  localparam logic [7:0] SOF1     = 8'hEF;
  localparam int         BODY_LEN = 8;
  localparam int         PKT_LEN  = 11;

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    BODY,
    CSUM
  } tx_state_t;

  // Running packet checksum: plain 8-bit sum that wraps.
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick of one requester
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  // First requester found searching upward from ptr, wrapping past N-1.
  always_comb begin
    int   idx;
    logic found;
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pkt_tx_sched.sv
// rtl/pkt_tx_sched.sv - round-robin packet framer sharing one byte link between sources
module pkt_tx_sched
  import pkt_pkg::*;
#(
  parameter int         N_SRC    = 2,
  parameter int         BODY_LEN = 8,
  parameter logic [7:0] SOF0     = 8'hBE,
  parameter logic [7:0] SOF1     = 8'hEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_SRC-1:0]   src_valid,
  input  logic [N_SRC*8-1:0] src_data,
  output logic [N_SRC-1:0]   src_ready,
  output logic               out_valid,
  output logic [7:0]         out_data,
  input  logic               out_ready,
  output logic [N_SRC-1:0]   grant,
  output logic               pkt_done,
  output logic               illegal_byte
);

  localparam int PW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int CW = $clog2(BODY_LEN);

  tx_state_t        state_q, state_d;
  logic [N_SRC-1:0] grant_q, grant_d;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [7:0]       csum_q, csum_d;

  logic [N_SRC-1:0] arb_gnt;
  logic [PW-1:0]    arb_ptr;
  logic [PW-1:0]    next_ptr;
  logic [PW-1:0]    g_idx;
  logic             g_valid;
  logic [7:0]       g_data;

  // Index, valid and byte of the source that owns the current packet.
  always_comb begin
    g_idx   = '0;
    g_valid = 1'b0;
    g_data  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant_q[i]) begin
        g_idx   = PW'(i);
        g_valid = src_valid[i];
        g_data  = src_data[8*i +: 8];
      end
    end
  end

  // Pointer after the current owner; CSUM re-arbitrates with it so the
  // owner that just finished drops to lowest priority.
  assign next_ptr = (int'(g_idx) == N_SRC - 1) ? '0 : g_idx + 1'b1;
  assign arb_ptr  = (state_q == CSUM) ? next_ptr : rr_ptr_q;

  rr_arbiter #(
    .N  (N_SRC),
    .PW (PW)
  ) u_arb (
    .req (src_valid),
    .ptr (arb_ptr),
    .gnt (arb_gnt)
  );

  // Framing FSM: next state, register updates and link/source handshakes.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_ptr_d     = rr_ptr_q;
    cnt_d        = cnt_q;
    csum_d       = csum_q;
    out_valid    = 1'b0;
    out_data     = '0;
    src_ready    = '0;
    pkt_done     = 1'b0;
    illegal_byte = 1'b0;
    case (state_q)
      IDLE: begin
        if (|src_valid) begin
          grant_d = arb_gnt;
          state_d = HDR0;
        end
      end
      HDR0: begin
        out_valid = 1'b1;
        out_data  = SOF0;
        if (out_ready) state_d = HDR1;
      end
      HDR1: begin
        out_valid = 1'b1;
        out_data  = SOF1;
        if (out_ready) begin
          state_d = BODY;
          cnt_d   = '0;
          csum_d  = '0;
        end
      end
      BODY: begin
        out_valid = g_valid;
        out_data  = g_data;
        src_ready = grant_q & {N_SRC{out_ready}};
        if (g_valid && out_ready) begin
          csum_d       = csum_add(csum_q, g_data);
          illegal_byte = (g_data == SOF0) || (g_data == SOF1);
          if (cnt_q == CW'(BODY_LEN - 1)) state_d = CSUM;
          else                            cnt_d   = cnt_q + 1'b1;
        end
      end
      CSUM: begin
        out_valid = 1'b1;
        out_data  = csum_q;
        if (out_ready) begin
          pkt_done = 1'b1;
          rr_ptr_d = next_ptr;
          if (|src_valid) begin
            grant_d = arb_gnt;
            state_d = HDR0;
          end else begin
            grant_d = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant = grant_q;

  // Scheduler registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      csum_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      csum_q   <= csum_d;
    end
  end

endmodule

// File: doc/pkt_tx_sched.md
Name: pkt_tx_sched

Overview:
- Transmit-side scheduler that shares one byte-wide packet link between N_SRC body producers.
- Picks a source round-robin and frames its packet: header 0xBE 0xEF, 8 body bytes pulled from that source, then a checksum byte (sum of the body bytes mod 256).
- Drives the same link format that the packet error detector checks, so the two blocks pair directly in loopback.

Parameters:
- N_SRC, 2, number of requesting sources (2..8).
- BODY_LEN, 8, body bytes per packet; the link format fixes this at 8.
- SOF0, 8'hBE, first header byte.
- SOF1, 8'hEF, second header byte.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- src_valid  in  N_SRC  per-source body byte valid; also serves as that source's request.
- src_data  in  N_SRC*8  per-source body byte; source i occupies bits [8i+7:8i].
- src_ready  out  N_SRC  per-source byte accept; at most one bit set.
- out_valid  out  1  link byte valid.
- out_data  out  8  link byte.
- out_ready  in  1  link backpressure from downstream.
- grant  out  N_SRC  one-hot owner of the current packet; 0 when idle.
- pkt_done  out  1  1-cycle pulse when the checksum byte is accepted.
- illegal_byte  out  1  1-cycle pulse when a body byte equal to SOF0 or SOF1 is accepted.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE, rr_ptr=0, body count=0, checksum accumulator=0.
  - All outputs 0.
- Transfer rules:
  - A link byte transfers when out_valid && out_ready.
  - A source byte transfers when src_valid[i] && src_ready[i].
  - out_valid/out_data must hold stable while out_ready=0.
- IDLE:
  - out_valid=0, grant=0.
  - If any src_valid bit is set, latch the winner into grant and move to HDR0 next cycle.
  - Latency from request to first header byte is 1 cycle.
- Arbitration:
  - Round-robin: search from rr_ptr upward, wrapping.
  - At reset, source 0 has highest priority.
  - rr_ptr <= winner+1 (mod N_SRC), updated only at packet end.
- HDR0: out_valid=1, out_data=SOF0; on transfer go to HDR1.
- HDR1: out_valid=1, out_data=SOF1; on transfer go to BODY with cnt=0 and csum=0.
- BODY:
  - out_valid = src_valid[g]; out_data = src_data[g]; src_ready[g] = out_ready. g is the granted source.
  - On transfer: csum <= csum + byte (8-bit, wraps), cnt++. After the transfer at cnt=BODY_LEN-1, go to CSUM.
  - If the source stalls (src_valid low), emit no byte and hold cnt and csum. The link simply carries no valid byte.
  - If a transferred byte equals SOF0 or SOF1, pulse illegal_byte and forward the byte unchanged. The packet is not aborted.
- CSUM:
  - out_valid=1, out_data=csum.
  - On transfer: pulse pkt_done and update rr_ptr.
  - If any src_valid is set in that same cycle, re-arbitrate using the updated pointer and go straight to HDR0 (back-to-back, no idle cycle). Otherwise go to IDLE and set grant=0.
- Grant is held for the whole packet. src_valid changes on other sources have no effect mid-packet.
- Deasserting the granted source's src_valid mid-body only stalls the packet; it never aborts it.
- Registers: state, grant, rr_ptr, cnt, csum.
- out_*, src_ready, pkt_done and illegal_byte are combinational decodes of the registers plus out_ready/src_valid. There is no combinational path from out_ready to out_valid.

Decomposition:
- Shared package pkt_pkg:
  - Constants SOF0, SOF1, BODY_LEN, PKT_LEN=11.
  - State enum tx_state_t {IDLE, HDR0, HDR1, BODY, CSUM}.
  - The checksum-add function, so the detector and the bench reuse it.
- One sub-module, rr_arbiter:
  - Inputs: request vector, rr_ptr.
  - Output: one-hot winner, combinational.
  - Instantiated once.

Test Plan:
- Single packet: after reset, src0 presents bytes 01..08 continuously, out_ready=1 → out_data BE EF 01 02 03 04 05 06 07 08 24 on 11 consecutive cycles, pkt_done at byte 11, grant=01 throughout.
- Contention: src0 and src1 both valid from the same cycle, each with 8 bytes of 10 → src0 packet (checksum 80), then src1 packet with no idle cycle between them. A third request from src0 in the next round is served after src1.
- Backpressure: hold out_ready=0 for 3 cycles during HDR1 and for 2 cycles at body byte 4 → out_data stays EF and byte-4 value respectively, src_ready=0 during the stall, total output still exactly 11 bytes.
- Source stall and wrap: src0 sends FF x8, with src_valid low for 2 cycles after byte 3 → out_valid low for those 2 cycles, cnt held, checksum F8.
- Illegal body byte: body 00 BE 00 00 00 00 00 00 → illegal_byte pulses once on the BE transfer, checksum BE, packet completes normally.
- Reset mid-packet: assert reset_n=0 during BODY cnt=5 → outputs go to 0 immediately. After release with both sources valid, src0 wins and the next packet starts with fresh BE EF and a fresh checksum.
